// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants and sequencer state encoding for the UART TX path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACT  = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_WAIT_CLR  = 2'd3
    } tx_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Purpose  : Single-clock byte FIFO with count-derived full/empty and a sticky
//            overflow flag for dropped writes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Wr_DV,
    input  logic [WIDTH-1:0]      i_Wr_Data,
    input  logic                  i_Rd_En,
    input  logic                  i_Clr_Overflow,
    output logic [WIDTH-1:0]      o_Rd_Data,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic                  o_Overflow
);

    localparam int                c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = (DEPTH_LOG2 + 1)'(c_DEPTH);

    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_rd_accept;

    assign w_full      = (r_count == c_FULL_COUNT);
    assign w_empty     = (r_count == '0);
    // Acceptance uses the pre-edge count, so a pop in the same cycle never frees a slot for the write.
    assign w_wr_accept = i_Wr_DV && !w_full;
    assign w_rd_accept = i_Rd_En && !w_empty;

    always_ff @(posedge i_Clock) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (i_Wr_DV && w_full) begin
                r_overflow <= 1'b1;
            end else if (i_Clr_Overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_Rd_Data  = r_mem[r_rd_ptr];
    assign o_Count    = r_count;
    assign o_Full     = w_full;
    assign o_Empty    = w_empty;
    assign o_Overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Buffers host bytes and hands them one at a time to the UART
//            transmitter, pacing on its active/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_Wr_DV,
    input  logic [c_DATA_WIDTH-1:0] i_Wr_Byte,
    input  logic                    i_Clr_Overflow,
    output logic                    o_Full,
    output logic                    o_Empty,
    output logic [DEPTH_LOG2:0]     o_Count,
    output logic                    o_Overflow,
    output logic                    o_Busy,
    output logic                    o_Tx_DV,
    output logic [c_DATA_WIDTH-1:0] o_Tx_Byte,
    input  logic                    i_Tx_Active,
    input  logic                    i_Tx_Done
);

    tx_seq_state_t           r_state;
    tx_seq_state_t           w_state_next;
    logic                    r_tx_dv;
    logic [c_DATA_WIDTH-1:0] r_tx_byte;
    logic                    w_pop;
    logic [c_DATA_WIDTH-1:0] w_head;
    logic                    w_empty;

    uart_sync_fifo #(
        .WIDTH      (c_DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_Wr_DV        (i_Wr_DV),
        .i_Wr_Data      (i_Wr_Byte),
        .i_Rd_En        (w_pop),
        .i_Clr_Overflow (i_Clr_Overflow),
        .o_Rd_Data      (w_head),
        .o_Count        (o_Count),
        .o_Full         (o_Full),
        .o_Empty        (w_empty),
        .o_Overflow     (o_Overflow)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= ST_IDLE;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
        end else begin
            r_state <= w_state_next;
            r_tx_dv <= w_pop;
            if (w_pop) begin
                r_tx_byte <= w_head;
            end
        end
    end

    // The transmitter is not reset with this block, so IDLE also waits out any frame still in flight.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !i_Tx_Active && !i_Tx_Done) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_WAIT_ACT;
                end
            end
            ST_WAIT_ACT: begin
                if (i_Tx_Active) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    w_state_next = ST_WAIT_CLR;
                end
            end
            ST_WAIT_CLR: begin
                if (!i_Tx_Done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_Empty   = w_empty;
    assign o_Busy    = !w_empty || (r_state != ST_IDLE);
    assign o_Tx_DV   = r_tx_dv;
    assign o_Tx_Byte = r_tx_byte;

endmodule
`default_nettype wire
